jstk_poller: RTL and testbench
==============================

// Module: jstk_poller
// PURPOSE
//  Periodic transaction controller for the PMOD JSTK joystick, sitting directly upstream of
//  the 40-bit SPI master. It pulses the master's trigger and builds the 5-byte command
//  (LED byte plus 4 dummy bytes). It watches chip-select for completion, then decodes the
//  40-bit response into X/Y position and buttons for the paddle logic.
// PARAMETERS
//  POLL_CYCLES     1_000_000  clk cycles between transaction starts (50 Hz at 50 MHz)
//  TRIG_HOLD       320        clk cycles trigger is held high; must satisfy 256 < TRIG_HOLD <= 512
//  TIMEOUT_CYCLES  65536      max clk cycles from trigger rise to cs rise before abort
// PORTS
//  clk            in   1   50 MHz system clock (same clock driving the SPI master)
//  reset          in   1   asynchronous, active-high reset
//  led            in   2   LED request {led2,led1}; sampled on entry to TRIG
//  spi_cs         in   1   SPI master ~chipselect (asynchronous to clk; synchronised inside)
//  spi_in_bytes   in   40  SPI master received data; byte0 = [39:32]
//  spi_trigger    out  1   start pulse to SPI master
//  spi_out_bytes  out  40  command to SPI master
//  x_pos          out  10  joystick X, 0..1023
//  y_pos          out  10  joystick Y, 0..1023
//  btn            out  3   {btn2,btn1,stick_btn}
//  sample_valid   out  1   one-cycle pulse when x/y/btn update
//  busy           out  1   high in any state other than IDLE
//  timeout_err    out  1   sticky; set on transaction timeout, cleared only by reset
// BEHAVIOUR
//  Reset values: spi_trigger=0, spi_out_bytes=40'h80_00_00_00_00, x_pos=y_pos=10'd512,
//   btn=0, sample_valid=0, busy=0, timeout_err=0, state=IDLE, counters=0, cs sync regs=1.
//  spi_cs passes through a 2-flop synchroniser (cs_s); edge detection uses cs_s and its delayed copy.
//  Poll counter is free-running; it counts 0..POLL_CYCLES-1 and wraps. poll_tick fires at wrap.
//   The first tick comes POLL_CYCLES cycles after reset deasserts.
//  A tick that arrives while not IDLE is dropped (no queueing); the counter keeps running.
//  FSM:
//   IDLE      : on poll_tick -> TRIG. Same edge: spi_out_bytes <= {6'b100000,led,32'h0}, timeout ctr=0.
//   TRIG      : spi_trigger=1 for exactly TRIG_HOLD cycles, then 0 -> WAIT_LOW.
//   WAIT_LOW  : wait for cs_s==0 (transfer started) -> WAIT_HIGH.
//   WAIT_HIGH : wait for cs_s==1 (transfer done) -> LATCH.
//   LATCH     : one cycle. Decode spi_in_bytes, which is stable once cs has risen:
//               x_pos <= {in[25:24], in[39:32]}; y_pos <= {in[9:8], in[23:16]};
//               btn <= in[2:0]. Pulse sample_valid. -> IDLE.
//  Upper bits of the high bytes (in[31:26], in[15:10]) and in[7:3] are ignored.
//  Timeout: the counter runs in TRIG, WAIT_LOW and WAIT_HIGH. When it reaches TIMEOUT_CYCLES-1:
//   force spi_trigger=0, go to IDLE, set timeout_err, keep x/y/btn, no sample_valid.
//  spi_out_bytes holds constant from TRIG entry until the next TRIG entry. A led change
//   mid-transfer affects the next transaction only.
//  TRIG_HOLD bound: the trigger must span at least one SPI clock edge (period 256 clk). It must
//   fall before sck starts (at least 2 SPI clock periods after sampling), else the shift registers stay reset.
//  Reset mid-transaction: all state returns to reset values immediately (async).
//   The SPI master completes its transfer on its own; the result is discarded.
//  Latency: a poll_tick leads to sample_valid in about TRIG_HOLD + 43*256 + 4 clk cycles.
// STRUCTURE
//  Shared package/header jstk_pkg: state encodings (IDLE/TRIG/WAIT_LOW/WAIT_HIGH/LATCH),
//   JSTK_CMD_LED=6'b100000, reset centre value 10'd512, byte-field bit offsets.
//  One sub-module: sync2 (2-flop synchroniser, reset value 1) for spi_cs.
//  FSM, poll counter, hold counter, timeout counter and output registers stay in jstk_poller.
// TESTING
//  Bench: spi_cs/spi_in_bytes from a behavioural model of the 40-bit SPI master (cs low 40*256 clk).
//  1 Reset -> x/y=512, btn=0, trigger=0, busy=0; first trigger exactly POLL_CYCLES clk after release.
//  2 Model returns 40'h34_02_C1_01_05 -> one sample_valid pulse, x=10'h234, y=10'h1C1, btn=3'b101.
//  3 led=2'b10 at tick -> spi_out_bytes=40'h82_00_00_00_00; led changes mid-transfer, bytes unchanged.
//  4 cs never falls -> timeout_err=1 after TIMEOUT_CYCLES, busy=0, outputs unchanged; the next poll still runs.
//  5 POLL_CYCLES=4000 (shorter than one transaction) -> ticks during busy dropped, no back-to-back trigger.
//  6 reset asserted in WAIT_HIGH -> immediate reset values; no sample_valid when that cs rises.

Source files
------------

// File: rtl/jstk_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jstk_pkg : shared encodings and field offsets for the PMOD JSTK poller
// Rev 1.0
// ---------------------------------------------------------------------------
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_LATCH     = 3'd4
  } state_t;

  localparam logic [5:0]  JSTK_CMD_LED = 6'b100000;
  localparam logic [9:0]  POS_CENTRE   = 10'd512;
  localparam logic [39:0] CMD_RESET    = {JSTK_CMD_LED, 2'b00, 32'h0};

  // Bit positions inside the 40-bit response; byte0 occupies [39:32]
  localparam int X_LO_MSB = 39;
  localparam int X_LO_LSB = 32;
  localparam int X_HI_MSB = 25;
  localparam int X_HI_LSB = 24;
  localparam int Y_LO_MSB = 23;
  localparam int Y_LO_LSB = 16;
  localparam int Y_HI_MSB = 9;
  localparam int Y_HI_LSB = 8;
  localparam int BTN_MSB  = 2;
  localparam int BTN_LSB  = 0;

  function automatic logic [39:0] make_cmd(input logic [1:0] led);
    return {JSTK_CMD_LED, led, 32'h0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/jstk_poller_sync2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync2 : two-flop synchroniser with selectable reset value
// Rev 1.0
// ---------------------------------------------------------------------------
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jstk_poller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jstk_poller : periodic PMOD JSTK transaction controller and response decoder
// Rev 1.0
// ---------------------------------------------------------------------------
module jstk_poller
  import jstk_pkg::*;
#(
  parameter int unsigned POLL_CYCLES    = 1_000_000,
  parameter int unsigned TRIG_HOLD      = 320,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  led,
  input  logic        spi_cs,
  input  logic [39:0] spi_in_bytes,
  output logic        spi_trigger,
  output logic [39:0] spi_out_bytes,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [2:0]  btn,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int HOLD_W = (TRIG_HOLD > 1) ? $clog2(TRIG_HOLD) + 1 : 2;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TRIG_HOLD - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;

  logic [POLL_W-1:0] poll_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic cs_s, cs_d, cs_rise;
  logic poll_tick, hold_done, tmo_active, tmo_hit;
  logic start_txn, latch_now;
  logic unused_in_bits;

  sync2 #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .d     (spi_cs),
    .q     (cs_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cs_d <= 1'b1;
    else       cs_d <= cs_s;
  end

  assign cs_rise   = cs_s & ~cs_d;
  assign poll_tick = (poll_cnt == POLL_LAST);
  assign hold_done = (hold_cnt == HOLD_LAST);

  // Reserved response bits are deliberately ignored
  assign unused_in_bits = ^{spi_in_bytes[31:26], spi_in_bytes[15:10], spi_in_bytes[7:3]};

  // Free-running poll timebase; ticks landing outside IDLE are simply lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          poll_cnt <= '0;
    else if (poll_tick) poll_cnt <= '0;
    else                poll_cnt <= poll_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_txn  = 1'b0;
    latch_now  = 1'b0;
    tmo_active = 1'b0;
    tmo_hit    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (poll_tick) begin
          state_next = ST_TRIG;
          start_txn  = 1'b1;
        end
      end
      ST_TRIG, ST_WAIT_LOW, ST_WAIT_HIGH: begin
        tmo_active = 1'b1;
        if (tmo_cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          state_next = ST_IDLE;
        end else if (state == ST_TRIG) begin
          if (hold_done) state_next = ST_WAIT_LOW;
        end else if (state == ST_WAIT_LOW) begin
          if (!cs_s) state_next = ST_WAIT_HIGH;
        end else begin
          if (cs_rise) state_next = ST_LATCH;
        end
      end
      ST_LATCH: begin
        latch_now  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      hold_cnt <= (state == ST_TRIG) ? hold_cnt + 1'b1 : '0;
      tmo_cnt  <= tmo_active ? tmo_cnt + 1'b1 : '0;
    end
  end

  // Outputs follow the next state so they change on the same edge as the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_trigger   <= 1'b0;
      busy          <= 1'b0;
      sample_valid  <= 1'b0;
      timeout_err   <= 1'b0;
      spi_out_bytes <= CMD_RESET;
      x_pos         <= POS_CENTRE;
      y_pos         <= POS_CENTRE;
      btn           <= '0;
    end else begin
      spi_trigger  <= (state_next == ST_TRIG);
      busy         <= (state_next != ST_IDLE);
      sample_valid <= latch_now;
      if (tmo_hit)   timeout_err   <= 1'b1;
      if (start_txn) spi_out_bytes <= make_cmd(led);
      if (latch_now) begin
        x_pos <= {spi_in_bytes[X_HI_MSB:X_HI_LSB], spi_in_bytes[X_LO_MSB:X_LO_LSB]};
        y_pos <= {spi_in_bytes[Y_HI_MSB:Y_HI_LSB], spi_in_bytes[Y_LO_MSB:Y_LO_LSB]};
        btn   <= spi_in_bytes[BTN_MSB:BTN_LSB];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jstk_poller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_jstk_poller : directed bench with SPI master model and event-level reference
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_jstk_poller;

  localparam int P = 4000;
  localparam int H = 320;
  localparam int T = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  led = 2'b00;
  logic        spi_cs = 1'b1;
  logic [39:0] spi_in_bytes = 40'h0;
  logic        spi_trigger;
  logic [39:0] spi_out_bytes;
  logic [9:0]  x_pos, y_pos;
  logic [2:0]  btn;
  logic        sample_valid, busy, timeout_err;

  always #5 clk = ~clk;

  jstk_poller #(
    .POLL_CYCLES    (P),
    .TRIG_HOLD      (H),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .led           (led),
    .spi_cs        (spi_cs),
    .spi_in_bytes  (spi_in_bytes),
    .spi_trigger   (spi_trigger),
    .spi_out_bytes (spi_out_bytes),
    .x_pos         (x_pos),
    .y_pos         (y_pos),
    .btn           (btn),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: transaction-level view indexed by edges since reset release
  int          cyc = 0;
  bit          m_busy = 0;
  bit          was_busy = 0;
  int          m_start = 0;
  int          m_done = -1;
  logic [39:0] m_resp = 40'h0;
  logic        e_trig = 0, e_busy = 0, e_sv = 0, e_err = 0;
  logic [9:0]  e_x = 10'd512, e_y = 10'd512;
  logic [2:0]  e_btn = 3'd0;
  logic [39:0] e_out = 40'h80_0000_0000;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0; m_busy = 0; m_done = -1;
      e_trig = 0; e_busy = 0; e_sv = 0; e_err = 0;
      e_x = 10'd512; e_y = 10'd512; e_btn = 3'd0;
      e_out = 40'h80_0000_0000;
    end else begin
      cyc++;
      e_sv = 0;
      was_busy = m_busy;
      if (m_busy && cyc == m_start + T) begin
        m_busy = 0;
        e_err  = 1;
      end else if (m_busy && cyc == m_done) begin
        m_busy = 0;
        e_sv   = 1;
        e_x    = 10'(((m_resp >> 24) % 4) * 256 + ((m_resp >> 32) % 256));
        e_y    = 10'(((m_resp >> 8) % 4) * 256 + ((m_resp >> 16) % 256));
        e_btn  = 3'(m_resp % 8);
      end
      if (cyc % P == 0 && !was_busy) begin
        m_busy  = 1;
        m_start = cyc;
        m_done  = -1;
        e_out   = 40'h80_0000_0000 + (40'(led) << 32);
      end
      e_busy = m_busy;
      e_trig = m_busy && (cyc < m_start + H);
    end
  end

  // SPI master model: samples trigger once per 256-clk SPI period, cs low 40 periods
  bit          no_cs = 0;
  bit          spi_busy = 0;
  int          low_cnt = 0;
  logic [39:0] resp_next = 40'h0;
  logic [7:0]  spi_ph = 8'd0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      spi_ph++;
      if (!spi_busy) begin
        if (spi_ph == 8'd0 && spi_trigger === 1'b1 && !no_cs) begin
          spi_busy     = 1;
          low_cnt      = 40 * 256;
          spi_cs       = 1'b0;
          spi_in_bytes = 40'hA5_A5_A5_A5_A5;
        end
      end else begin
        low_cnt--;
        if (low_cnt == 0) begin
          spi_in_bytes = resp_next;
          m_resp       = resp_next;
          m_done       = cyc + 4;
          spi_cs       = 1'b1;
          spi_busy     = 0;
        end
      end
    end
  end

  bit   cmp_en = 0;
  int   sv_cnt = 0;
  int   rise_cyc = -1;
  logic prev_trig = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check($sformatf("cycle%0d", cyc),
            {spi_trigger, busy, sample_valid, timeout_err, x_pos, y_pos, btn, spi_out_bytes},
            {e_trig, e_busy, e_sv, e_err, e_x, e_y, e_btn, e_out});
      if (sample_valid) sv_cnt++;
      if (spi_trigger && !prev_trig) rise_cyc = cyc;
      prev_trig = spi_trigger;
    end
  end

  task automatic wait_cyc(input int target);
    int g = 0;
    while (cyc < target && g < 100000) begin
      @(negedge clk); #1;
      g++;
    end
    check($sformatf("reach_cyc%0d", target), 67'(cyc >= target), 67'(1));
  endtask

  task automatic wait_sv(input int budget);
    int g = 0;
    while (!sample_valid && g < budget) begin
      @(negedge clk); #1;
      g++;
    end
    check("sv_seen", 67'(sample_valid), 67'(1));
  endtask

  int sv_before;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    cmp_en = 1;
    check("rst_x", x_pos, 10'd512);
    check("rst_y", y_pos, 10'd512);
    check("rst_btn", btn, 3'd0);
    check("rst_trig", spi_trigger, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out", spi_out_bytes, 40'h80_0000_0000);
    @(posedge clk); #1 reset = 1'b0;

    // Transaction A: led sampled at tick, led changed mid-transfer
    led = 2'b10;
    resp_next = 40'h34_02_C1_01_05;
    wait_cyc(P);
    check("first_trig_cyc", 67'(rise_cyc), 67'(P));
    check("out_led10", spi_out_bytes, 40'h82_0000_0000);
    led = 2'b01;
    wait_cyc(5000);
    check("out_hold", spi_out_bytes, 40'h82_0000_0000);
    wait_sv(20000);
    check("a_x", x_pos, 10'h234);
    check("a_y", y_pos, 10'h1C1);
    check("a_btn", btn, 3'b101);
    check("a_busy", busy, 1'b0);

    // Transaction B: ticks at 8000/12000 dropped, next start at 16000
    resp_next = 40'hFF_FF_FF_FF_FF;
    wait_cyc(4 * P);
    check("b_trig_cyc", 67'(rise_cyc), 67'(4 * P));
    check("b_out", spi_out_bytes, 40'h81_0000_0000);
    wait_sv(20000);
    check("b_x", x_pos, 10'h3FF);
    check("b_y", y_pos, 10'h3FF);
    check("b_btn", btn, 3'b111);

    // Transaction C: cs never falls
    no_cs = 1;
    sv_before = sv_cnt;
    wait_cyc(7 * P);
    check("c_trig_cyc", 67'(rise_cyc), 67'(7 * P));
    wait_cyc(7 * P + T - 1);
    check("c_err_before", timeout_err, 1'b0);
    check("c_busy_before", busy, 1'b1);
    wait_cyc(7 * P + T);
    check("c_err", timeout_err, 1'b1);
    check("c_busy", busy, 1'b0);
    check("c_trig", spi_trigger, 1'b0);
    check("c_x_kept", x_pos, 10'h3FF);
    check("c_no_sv", 67'(sv_cnt), 67'(sv_before));
    no_cs = 0;

    // Transaction D: polling resumes; reserved bits set but ignored
    resp_next = 40'h00_FC_00_FC_F8;
    wait_cyc(12 * P);
    check("d_trig_cyc", 67'(rise_cyc), 67'(12 * P));
    wait_sv(20000);
    check("d_x", x_pos, 10'h000);
    check("d_y", y_pos, 10'h000);
    check("d_btn", btn, 3'b000);
    check("d_err_sticky", timeout_err, 1'b1);

    // Transaction E: reset while waiting for cs to rise
    resp_next = 40'h12_03_45_02_03;
    wait_cyc(15 * P);
    begin
      int g = 0;
      while (!(spi_busy && low_cnt <= 200) && g < 20000) begin
        @(negedge clk); #1;
        g++;
      end
    end
    check("e_in_transfer", 67'(spi_busy), 67'(1));
    check("e_busy", busy, 1'b1);
    #1 reset = 1'b1;
    sv_cnt = 0;
    @(negedge clk); #1;
    check("e_rst_x", x_pos, 10'd512);
    check("e_rst_busy", busy, 1'b0);
    check("e_rst_err", timeout_err, 1'b0);
    check("e_rst_out", spi_out_bytes, 40'h80_0000_0000);
    @(posedge clk); #1 reset = 1'b0;
    begin
      int g = 0;
      while (spi_busy && g < 2000) begin
        @(negedge clk); #1;
        g++;
      end
    end
    repeat (20) @(negedge clk);
    #1;
    check("e_no_sv", 67'(sv_cnt), 67'(0));
    check("e_x_centre", x_pos, 10'd512);
    wait_cyc(P);
    check("e_retrig_cyc", 67'(rise_cyc), 67'(P));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
